// File: rtl/key_cmd_ctrl.sv
// key_cmd_ctrl: turns PS/2 scan codes and gravity ticks into one-at-a-time game commands.
// Build with KEY_CMD_REPEAT_EN to include auto-repeat of held LEFT/RIGHT/SOFT keys.
module key_cmd_ctrl #(
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    output logic       kb_rdn,
    input  logic       tick,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       paused,
    output logic [3:0] held
);

    typedef enum logic [1:0] {IDLE, POP, GAP} rx_state_e;

    localparam logic [2:0] C_LEFT  = 3'd0;
    localparam logic [2:0] C_RIGHT = 3'd1;
    localparam logic [2:0] C_ROT   = 3'd2;
    localparam logic [2:0] C_SOFT  = 3'd3;
    localparam logic [2:0] C_DROP  = 3'd4;
    localparam logic [2:0] C_GRAV  = 3'd5;
    localparam logic [2:0] C_PAUSE = 3'd6;

    rx_state_e  state_q, state_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] held_q, held_d;
    logic [6:0] pend_q, pend_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_q, cmd_d;
    logic       paused_q, paused_d;

    logic       byte_take;
    logic       code_hit;
    logic [2:0] code_idx;
    logic       key_make;
    logic       key_brk;
    logic       accept;
    logic       block;
    logic       issue;
    logic [2:0] sel;
    logic [6:0] ev_set;
    logic [6:0] rpt_set;
    logic [6:0] issue_clr;

    assign byte_take = (state_q == IDLE) && kb_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (kb_ready) state_d = POP;
            POP:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Prefix bytes only arm flags; any other byte completes a code.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        code_hit = 1'b0;
        code_idx = C_LEFT;
        if (byte_take) begin
            if (kb_data == 8'hE0) begin
                ext_d = 1'b1;
            end else if (kb_data == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q) begin
                    case (kb_data)
                        8'h6B:   begin code_hit = 1'b1; code_idx = C_LEFT;  end
                        8'h74:   begin code_hit = 1'b1; code_idx = C_RIGHT; end
                        8'h75:   begin code_hit = 1'b1; code_idx = C_ROT;   end
                        8'h72:   begin code_hit = 1'b1; code_idx = C_SOFT;  end
                        default: code_hit = 1'b0;
                    endcase
                end else begin
                    case (kb_data)
                        8'h29:   begin code_hit = 1'b1; code_idx = C_DROP;  end
                        8'h4D:   begin code_hit = 1'b1; code_idx = C_PAUSE; end
                        default: code_hit = 1'b0;
                    endcase
                end
            end
        end
    end

    assign key_make = code_hit && !brk_q;
    assign key_brk  = code_hit && brk_q;

    // Codes 0..3 own a held bit; a make of an already held key is typematic.
    always_comb begin
        held_d = held_q;
        ev_set = '0;
        if (key_make) begin
            if (code_idx[2]) begin
                ev_set[code_idx] = 1'b1;
            end else if (!held_q[code_idx[1:0]]) begin
                held_d[code_idx[1:0]] = 1'b1;
                ev_set[code_idx]      = 1'b1;
            end
        end
        if (key_brk && !code_idx[2]) held_d[code_idx[1:0]] = 1'b0;
        if (tick) ev_set[C_GRAV] = 1'b1;
    end

    always_comb begin
        sel = C_GRAV;
        if (pend_q[C_PAUSE])      sel = C_PAUSE;
        else if (pend_q[C_DROP])  sel = C_DROP;
        else if (pend_q[C_ROT])   sel = C_ROT;
        else if (pend_q[C_LEFT])  sel = C_LEFT;
        else if (pend_q[C_RIGHT]) sel = C_RIGHT;
        else if (pend_q[C_SOFT])  sel = C_SOFT;
    end

    assign accept = cmd_valid_q && cmd_ready;
    assign issue  = !cmd_valid_q && (pend_q != '0);

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        issue_clr   = '0;
        if (accept) begin
            cmd_valid_d = 1'b0;
        end else if (issue) begin
            cmd_valid_d    = 1'b1;
            cmd_d          = sel;
            issue_clr[sel] = 1'b1;
        end
    end

    assign paused_d = paused_q ^ (accept && (cmd_q == C_PAUSE));
    // Gate on both edges of a pause toggle so nothing slips in while paused shows 1.
    assign block    = paused_q || paused_d;

    always_comb begin
        pend_d = (pend_q & ~issue_clr) | ev_set | rpt_set;
        if (block) pend_d = pend_d & 7'b100_0000;
    end

`ifdef KEY_CMD_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tgt_q, tgt_d;
    logic             new_mov;

    assign new_mov = key_make && !code_idx[2] && (code_idx != C_ROT)
                     && !held_q[code_idx[1:0]];

    // Counter value 0 means no repeat target is armed.
    always_comb begin
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        rpt_set = '0;
        if (cnt_q == ONE) begin
            rpt_set[{1'b0, tgt_q}] = 1'b1;
            cnt_d                  = RATE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
        if (new_mov) begin
            tgt_d = code_idx[1:0];
            cnt_d = DLY;
        end else if (key_brk && !code_idx[2] && (code_idx[1:0] == tgt_q)) begin
            cnt_d = '0;
        end
        if (block) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tgt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE, CNT_W};
    assign rpt_set    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= '0;
            pend_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 3'd0;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            pend_q      <= pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            paused_q    <= paused_d;
        end
    end

    assign kb_rdn    = (state_q != POP);
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign paused    = paused_q;
    assign held      = held_q;

endmodule
